// File: rtl/iobus_input_stage.sv
// rtl/iobus_input_stage.sv - synchronizing, glitch-filtering input stage for the AC input bus
//
// Purpose:
//   Brings the asynchronous active-low converter lines (12-bit AC input word,
//   skip, interrupt request) into the clk domain through two-flop
//   synchronizers, optionally debounces them, and captures the word and skip
//   on each rising edge of the IOP strobe. A two-state capture controller
//   tracks whether the consumer has taken the capture and flags overruns.
//
// Configuration:
//   IOBUS_INPUT_FILTER_EN - when defined, each group (data word, skip, int)
//   only accepts a new level after it has been stable for FILT_LEN cycles.
//   When undefined the filtered value is the synchronizer output itself.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   bus_data_n   in   12-bit active-low AC input lines (asynchronous)
//   skip_n       in   active-low skip line (asynchronous)
//   int_rq_n     in   active-low interrupt request line (asynchronous)
//   iop_strobe   in   IOP window, synchronous to clk
//   data_ack     in   consumer has taken data_q/skip_q
//   overrun_clr  in   clears the sticky overrun flag
//   data_q       out  captured AC input word, positive logic
//   skip_q       out  captured skip, positive logic
//   data_valid   out  an unacknowledged capture is held
//   overrun      out  sticky: a capture overwrote an unacknowledged one
//   int_req      out  filtered interrupt request, positive logic, level

module iobus_input_stage #(
    parameter int FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bus_data_n,
    input  logic        skip_n,
    input  logic        int_rq_n,
    input  logic        iop_strobe,
    input  logic        data_ack,
    input  logic        overrun_clr,
    output logic [11:0] data_q,
    output logic        skip_q,
    output logic        data_valid,
    output logic        overrun,
    output logic        int_req
);

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("FILT_LEN must be in 1..15");
    end

    // Bit layout of the synchronized vector: {int, skip, data[11:0]}
    logic [13:0] sync_meta;
    logic [13:0] sync_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '1;
            sync_s    <= '1;
        end else begin
            sync_meta <= {int_rq_n, skip_n, bus_data_n};
            sync_s    <= sync_meta;
        end
    end

    logic [11:0] f_data;
    logic        f_skip;
    logic        f_int;

`ifdef IOBUS_INPUT_FILTER_EN
    localparam logic [4:0] FILT_TGT = 5'(FILT_LEN);

    logic [3:0] cnt_data;
    logic [3:0] cnt_skip;
    logic [3:0] cnt_int;

    // Counter holds the number of completed cycles for which s has kept its
    // current value while differing from f. Acceptance is checked before the
    // change test so a value that just completed its run is still taken even
    // if s moves on at the same edge. sync_meta != sync_s means s changes at
    // this edge, so the run of the next value starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_data   <= '1;
            cnt_data <= '0;
        end else if (sync_s[11:0] == f_data) begin
            cnt_data <= '0;
        end else if ({1'b0, cnt_data} + 5'd1 == FILT_TGT) begin
            f_data   <= sync_s[11:0];
            cnt_data <= '0;
        end else if (sync_meta[11:0] != sync_s[11:0]) begin
            cnt_data <= '0;
        end else begin
            cnt_data <= cnt_data + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_skip   <= 1'b1;
            cnt_skip <= '0;
        end else if (sync_s[12] == f_skip) begin
            cnt_skip <= '0;
        end else if ({1'b0, cnt_skip} + 5'd1 == FILT_TGT) begin
            f_skip   <= sync_s[12];
            cnt_skip <= '0;
        end else if (sync_meta[12] != sync_s[12]) begin
            cnt_skip <= '0;
        end else begin
            cnt_skip <= cnt_skip + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_int   <= 1'b1;
            cnt_int <= '0;
        end else if (sync_s[13] == f_int) begin
            cnt_int <= '0;
        end else if ({1'b0, cnt_int} + 5'd1 == FILT_TGT) begin
            f_int   <= sync_s[13];
            cnt_int <= '0;
        end else if (sync_meta[13] != sync_s[13]) begin
            cnt_int <= '0;
        end else begin
            cnt_int <= cnt_int + 4'd1;
        end
    end
`else
    assign f_data = sync_s[11:0];
    assign f_skip = sync_s[12];
    assign f_int  = sync_s[13];
`endif

    // History flop resets high so a strobe already asserted at reset
    // release does not look like a fresh edge.
    logic strobe_d;
    logic strobe_edge;

    assign strobe_edge = iop_strobe & ~strobe_d;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } cap_state_t;

    cap_state_t state;
    cap_state_t state_nx;
    logic       capture;
    logic       set_ovr;

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        set_ovr  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (strobe_edge) begin
                    state_nx = ST_FULL;
                    capture  = 1'b1;
                end
            end
            ST_FULL: begin
                if (strobe_edge) begin
                    capture = 1'b1;
                    set_ovr = ~data_ack;
                end else if (data_ack) begin
                    state_nx = ST_EMPTY;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            strobe_d <= 1'b1;
            data_q   <= '0;
            skip_q   <= 1'b0;
            overrun  <= 1'b0;
            int_req  <= 1'b0;
        end else begin
            state    <= state_nx;
            strobe_d <= iop_strobe;
            int_req  <= ~f_int;
            if (capture) begin
                data_q <= ~f_data;
                skip_q <= ~f_skip;
            end
            // Set wins over clear when both land in the same cycle.
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign data_valid = (state == ST_FULL);

endmodule

// File: doc/iobus_input_stage.md
IOBUS_INPUT_STAGE -- requirements
Module: iobus_input_stage

Interface
REQ-001 SHALL provide parameter FILT_LEN, default 3, range 1..15: consecutive stable cycles required before the glitch filter accepts a new level.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port bus_data_n, input, 12 bits: active-low AC input lines from the negative input converters; asynchronous to clk.
REQ-005 SHALL have port skip_n, input, 1 bit: active-low skip line from a converter; asynchronous.
REQ-006 SHALL have port int_rq_n, input, 1 bit: active-low interrupt-request line from a converter; asynchronous.
REQ-007 SHALL have port iop_strobe, input, 1 bit: IOP window from processor timing; synchronous to clk.
REQ-008 SHALL have port data_ack, input, 1 bit: consumer has taken data_q/skip_q.
REQ-009 SHALL have port overrun_clr, input, 1 bit: clears the sticky overrun flag.
REQ-010 SHALL have port data_q, output, 12 bits: captured AC input word, positive logic.
REQ-011 SHALL have port skip_q, output, 1 bit: captured skip, positive logic.
REQ-012 SHALL have port data_valid, output, 1 bit: data_q/skip_q hold an unacknowledged capture.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag for a capture that overwrote an unacknowledged one.
REQ-014 SHALL have port int_req, output, 1 bit: filtered interrupt request, positive logic, level.

Function
REQ-015 SHALL pass every asynchronous input through a two-flop synchronizer. The second-stage value is "s". An input change before edge N appears on s at edge N+1.
REQ-016 SHALL filter three independent groups: the 12-bit data word, skip, and int. For each group:
- f takes the value of s only after s has held one value, different from f, for FILT_LEN consecutive cycles.
- Any change of s, or s equal to f, resets that group's counter to 0.
REQ-017 SHALL give default filter latency as follows: input change before edge 1 gives s change at edge 2 and f change at edge 5.
REQ-018 SHALL never update f on a pulse shorter than FILT_LEN cycles at s.
REQ-019 SHALL detect a rising edge of iop_strobe (high this cycle, low the previous cycle). At the next edge it SHALL load data_q with the inverse of f_data and skip_q with the inverse of f_skip.
REQ-020 SHALL hold iop_strobe high for multiple cycles as one capture; no recapture until it falls and rises again.
REQ-021 SHALL operate the capture controller as FSM EMPTY/FULL, reset state EMPTY:
- EMPTY + strobe edge: go to FULL.
- FULL + data_ack without strobe edge: go to EMPTY.
- FULL + strobe edge without data_ack: stay FULL, overwrite data, set overrun.
- FULL + strobe edge with data_ack in the same cycle: stay FULL, overwrite data, do not set overrun.
REQ-022 SHALL drive data_valid high exactly when the FSM is in FULL.
REQ-023 SHALL ignore data_ack while EMPTY.
REQ-024 SHALL hold overrun until overrun_clr. If overrun_clr and an overrun-setting event occur in the same cycle, the flag SHALL end set.
REQ-025 SHALL register int_req as the inverse of f_int, one cycle after f_int changes.
REQ-026 SHALL leave data_q/skip_q unchanged except on capture.

Reset
REQ-027 SHALL, on reset, set:
- synchronizer flops and all f to all-ones (inactive);
- counters to 0;
- data_q = 0, skip_q = 0;
- data_valid = 0 (FSM EMPTY), overrun = 0, int_req = 0;
- the iop_strobe history flop to 1, so a strobe already high at reset release is not captured.
REQ-028 SHALL, on reset asserted mid-operation (mid-filter or FULL), discard all pending state at that edge; a filter restarts counting from 0 after release.

Configuration
REQ-029 SHALL compile in the glitch filter with macro IOBUS_INPUT_FILTER_EN. When it is defined, REQ-016..REQ-018 apply. When it is undefined, f equals s combinationally, counters are absent, FILT_LEN is ignored, and total input-to-f latency is 2 cycles.

Verification
REQ-030 SHALL cover filter acceptance: bus_data_n driven from 0xFFF to 0xA5A, held for 10 cycles, then a strobe edge. Required: data_q = 0x5A5, data_valid = 1, f changed at cycle 5 after the input change.
REQ-031 SHALL cover glitch rejection: skip_n pulsed low for 2 cycles, then a strobe edge. Required: skip_q = 0. With IOBUS_INPUT_FILTER_EN undefined, a 3-cycle pulse aligned to the strobe gives skip_q = 1.
REQ-032 SHALL cover overrun: two strobe edges with no data_ack, second with bus_data_n = 0xFFE. Required: data_q = 0x001, overrun = 1; overrun_clr gives overrun = 0.
REQ-033 SHALL cover simultaneous events: strobe edge coincident with data_ack in FULL. Required: data_valid stays 1, new data loaded, overrun stays 0.
REQ-034 SHALL cover reset behaviour:
- reset asserted while FULL with int_rq_n low: next cycle data_valid = 0, int_req = 0;
- after release, int_req = 1 at cycle 2+FILT_LEN+1 (post-release edges);
- iop_strobe held high across reset release gives no capture.
